// File: rtl/dff_share_arb_pkg.sv
// rtl/dff_share_arb_pkg.sv - shared types and width helpers for the shared D-register arbiter
// Purpose: FSM state encoding, default parameter values and index/counter width helpers.
// Ports: none (package).
package dff_share_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Requester index width, IDX_W = clog2(N); never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter width, CNT_W = clog2(MAX_HOLD+1), so it can reach MAX_HOLD.
  function automatic int cnt_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/dff_share_arb_if.sv
// rtl/dff_share_arb_if.sv - requester/arbiter bus for the shared D-register arbiter
// Purpose: bundles request/data inputs and grant/register outputs.
// Ports: req[N], d[N*WIDTH] (requesters -> arbiter); gnt[N], owner, busy, q, q_valid (arbiter -> requesters).
interface dff_share_arb_if
  import dff_share_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDX_W = idx_w(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] d;
  logic [N-1:0]       gnt;
  logic [IDX_W-1:0]   owner;
  logic               busy;
  logic [WIDTH-1:0]   q;
  logic               q_valid;

  modport master (
    output req, d,
    input  gnt, owner, busy, q, q_valid
  );

  modport slave (
    input  req, d,
    output gnt, owner, busy, q, q_valid
  );
endinterface

// File: rtl/dff_share_arb_rr_pick.sv
// rtl/dff_share_arb_rr_pick.sv - combinational round-robin picker
// Purpose: selects the first set request scanning ptr, ptr+1, ... modulo N.
// Ports: req[N] requests, ptr starting index; winner chosen index, any_req at least one request set.
module dff_share_arb_rr_pick
  import dff_share_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = idx_w(DEF_N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  int j;

  // Scan from the farthest offset down to offset 0 so the closest
  // request to ptr is the last (and therefore surviving) assignment.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        winner  = IDX_W'(j);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_share_arb.sv
// rtl/dff_share_arb.sv - round-robin owner of one shared WIDTH-bit D-register
// Purpose: grants one requester at a time, captures its data each granted edge, caps hold at MAX_HOLD captures.
// Ports: clk, rst_n (async active-low); bus.slave carries req/d in and gnt/owner/busy/q/q_valid out.
module dff_share_arb
  import dff_share_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic            clk,
  input  logic            rst_n,
  dff_share_arb_if.slave  bus
);

  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = cnt_w(MAX_HOLD);

  state_e             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               owner_req;
  logic [WIDTH-1:0]   owner_data;

  dff_share_arb_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_req  = bus.req[owner_q];
  assign owner_data = bus.d[int'(owner_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    // release: set when the owner drops its request or exhausts its hold budget
    begin : fsm
      logic release_now;
      release_now = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << winner;
            owner_d = winner;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (owner_req) begin
            q_d       = owner_data;
            q_valid_d = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MAX_HOLD - 1)) release_now = 1'b1;
          end else begin
            release_now = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // The releasing owner moves to lowest priority; owner itself is kept.
      if (release_now) begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        ptr_d   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_dff_share_arb.sv
// tb/tb_dff_share_arb.sv - directed self-checking bench for dff_share_arb (MAX_HOLD=4 and MAX_HOLD=1 builds)
module tb_dff_share_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dff_share_arb_if #(.N(4), .WIDTH(8)) bus0 ();
  dff_share_arb_if #(.N(4), .WIDTH(8)) bus1 ();

  dff_share_arb #(.N(4), .WIDTH(8), .MAX_HOLD(4)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  dff_share_arb #(.N(4), .WIDTH(8), .MAX_HOLD(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] d;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic        qv;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [3:0] gnt, input logic [1:0] owner,
                      input logic busy, input logic [7:0] q, input logic qv);
    chk({tag, ".gnt"},   32'(bus0.gnt),     32'(gnt));
    chk({tag, ".owner"}, 32'(bus0.owner),   32'(owner));
    chk({tag, ".busy"},  32'(bus0.busy),    32'(busy));
    chk({tag, ".q"},     32'(bus0.q),       32'(q));
    chk({tag, ".qv"},    32'(bus0.q_valid), 32'(qv));
  endtask

  initial begin
    logic [31:0] fdata;
    int          order [5];
    logic [7:0]  exp_q;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus0.req = '0; bus0.d = '0;
    bus1.req = '0; bus1.d = '0;

    //                 req      d             gnt      o  b  q      qv
    tbl[0]  = '{4'b0001, 32'h000000A5, 4'b0001, 0, 1, 8'h00, 0};
    tbl[1]  = '{4'b0001, 32'h000000A5, 4'b0001, 0, 1, 8'hA5, 1};
    tbl[2]  = '{4'b0001, 32'h000000A5, 4'b0001, 0, 1, 8'hA5, 1};
    tbl[3]  = '{4'b0000, 32'h000000A5, 4'b0000, 0, 0, 8'hA5, 0};
    tbl[4]  = '{4'b0000, 32'h00000000, 4'b0000, 0, 0, 8'hA5, 0};
    tbl[5]  = '{4'b0100, 32'h00090000, 4'b0100, 2, 1, 8'hA5, 0};
    tbl[6]  = '{4'b0100, 32'h00100000, 4'b0100, 2, 1, 8'h10, 1};
    tbl[7]  = '{4'b0100, 32'h00110000, 4'b0100, 2, 1, 8'h11, 1};
    tbl[8]  = '{4'b0100, 32'h00120000, 4'b0100, 2, 1, 8'h12, 1};
    tbl[9]  = '{4'b0100, 32'h00130000, 4'b0000, 2, 0, 8'h13, 1};
    tbl[10] = '{4'b0100, 32'h00140000, 4'b0100, 2, 1, 8'h13, 0};
    tbl[11] = '{4'b0000, 32'h00000000, 4'b0000, 2, 0, 8'h13, 0};
    tbl[12] = '{4'b0010, 32'h00005500, 4'b0010, 1, 1, 8'h13, 0};
    tbl[13] = '{4'b0010, 32'h00005500, 4'b0010, 1, 1, 8'h55, 1};
    tbl[14] = '{4'b1000, 32'hF0000000, 4'b0000, 1, 0, 8'h55, 0};
    tbl[15] = '{4'b1000, 32'hF0000000, 4'b1000, 3, 1, 8'h55, 0};
    tbl[16] = '{4'b1000, 32'hF0000000, 4'b1000, 3, 1, 8'hF0, 1};
    tbl[17] = '{4'b1001, 32'hF0000077, 4'b1000, 3, 1, 8'hF0, 1};
    tbl[18] = '{4'b0000, 32'hF0000077, 4'b0000, 3, 0, 8'hF0, 0};
    tbl[19] = '{4'b1001, 32'hF0000077, 4'b0001, 0, 1, 8'hF0, 0};
    tbl[20] = '{4'b0000, 32'h00000000, 4'b0000, 0, 0, 8'hF0, 0};

    // reset state
    #12;
    chk0("reset", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    step();

    // fairness: all four requesting, d_i = 8'h11*(i+1)
    fdata = 32'h44332211;
    order = '{0, 1, 2, 3, 0};
    bus0.d   = fdata;
    bus0.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("fair%0d.gnt", g),   32'(bus0.gnt),   32'(1) << order[g]);
      chk($sformatf("fair%0d.owner", g), 32'(bus0.owner), 32'(order[g]));
      chk($sformatf("fair%0d.qv0", g),   32'(bus0.q_valid), 32'd0);
      exp_q = 8'(fdata >> (8 * order[g]));
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("fair%0d.cap%0d.qv", g, c), 32'(bus0.q_valid), 32'd1);
        chk($sformatf("fair%0d.cap%0d.q", g, c),  32'(bus0.q),       32'(exp_q));
      end
      chk($sformatf("fair%0d.rel.gnt", g),  32'(bus0.gnt),  32'd0);
      chk($sformatf("fair%0d.rel.busy", g), 32'(bus0.busy), 32'd0);
    end
    bus0.req = '0;
    step();

    // async reset mid-grant with q=3C
    bus0.req = 4'b0001;
    bus0.d   = 32'h0000003C;
    step();
    step();
    chk("pre_rst.q",    32'(bus0.q),    32'h3C);
    chk("pre_rst.busy", 32'(bus0.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk0("async_rst", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b1;
    bus0.req = '0;
    bus0.d   = '0;
    step();
    step();
    chk0("post_rst", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);

    // table: single request, hold limit, handoff race, non-owner ignored, ptr wrap
    for (int i = 0; i < 21; i++) begin
      bus0.req = tbl[i].req;
      bus0.d   = tbl[i].d;
      step();
      chk0($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].owner, tbl[i].busy, tbl[i].q, tbl[i].qv);
    end

    // MAX_HOLD=1 build: req 0011 gives 0,1,0,1 single-capture grants with idle bubbles
    bus1.d   = 32'h0000B1B0;
    bus1.req = 4'b0011;
    order    = '{0, 1, 0, 1, 0};
    for (int g = 0; g < 4; g++) begin
      step();
      chk($sformatf("mh1_%0d.gnt", g),   32'(bus1.gnt),     32'(1) << order[g]);
      chk($sformatf("mh1_%0d.owner", g), 32'(bus1.owner),   32'(order[g]));
      chk($sformatf("mh1_%0d.qv0", g),   32'(bus1.q_valid), 32'd0);
      step();
      chk($sformatf("mh1_%0d.rel.gnt", g),  32'(bus1.gnt),     32'd0);
      chk($sformatf("mh1_%0d.rel.busy", g), 32'(bus1.busy),    32'd0);
      chk($sformatf("mh1_%0d.rel.qv", g),   32'(bus1.q_valid), 32'd1);
      chk($sformatf("mh1_%0d.rel.q", g),    32'(bus1.q),       (order[g] == 0) ? 32'hB0 : 32'hB1);
    end
    bus1.req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_share_arb.md
Name: dff_share_arb

Overview:
- Round-robin controller that shares one WIDTH-bit D-register (dff storage) among N requesters.
- Grants exclusive write access to one requester at a time and captures that requester's data on each granted clock edge.
- A hold counter caps how long one owner keeps the register.
- Sits in front of the dff storage used in the sequential practice designs and sequences who drives d.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, data and register width
MAX_HOLD, 4, max captures per grant (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request per requester, level
d  input  N*WIDTH  requester data, slice i = d[i*WIDTH +: WIDTH]
gnt  output  N  one-hot grant, registered
owner  output  clog2(N)  index of current/last owner, registered
busy  output  1  1 while in BUSY
q  output  WIDTH  shared register contents
q_valid  output  1  1-cycle pulse: q updated on this edge

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
  - rst_n=0 immediately forces state=IDLE, gnt=0, owner=0, busy=0, q=0, q_valid=0, ptr=0, cnt=0, with no clock required.
  - Reset mid-grant drops the grant without capture.
- ptr is internal and holds the starting priority index.
- States: IDLE, BUSY.
- IDLE, at each edge:
  - If req==0: stay IDLE, q_valid<=0.
  - Else winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod N.
  - On a win: gnt<=onehot(winner), owner<=winner, busy<=1, cnt<=0, state<=BUSY.
  - No capture happens in the IDLE cycle.
- BUSY, at each edge (o = owner):
  - If req[o]=1: q<=d[o], q_valid<=1, cnt<=cnt+1.
    - If cnt==MAX_HOLD-1, also release.
  - If req[o]=0: release with no capture, q_valid<=0.
- Release:
  - gnt<=0, busy<=0, state<=IDLE, ptr<=(o+1) mod N.
  - owner keeps its value.
- Grant latency: req sampled in IDLE at edge k gives gnt at k+1. First capture is at edge k+2 if req is still high.
- Every release spends exactly one cycle in IDLE (arbitration bubble). There are no back-to-back grants.
- Requests from non-owners are ignored while BUSY. Their d is never captured.
- Simultaneous owner drop and another raise: the owner releases, and the next IDLE edge arbitrates normally from the new ptr.
- Forced release with req[o] still high: the owner competes again in IDLE but has lowest priority (ptr=o+1). It wins only if no one else requests.
- q holds its value whenever q_valid=0.
- q_valid is registered and aligned with the q update.
- cnt width is clog2(MAX_HOLD+1).
- ptr wraps from N-1 to 0.

Decomposition:
- Shared header/package holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1
  - width helper constant IDX_W=clog2(N)
  - CNT_W derived from MAX_HOLD
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: winner index and any_req.
- The top level holds the FSM, counter and data register.

Test Plan:
- Async reset: in BUSY with q=8'h3C, drop rst_n between edges -> gnt=0, busy=0, q=0, q_valid=0 immediately. Release rst_n, no req -> outputs stay 0.
- Single short request: req=4'b0001, d0=8'hA5, held 3 cycles then dropped.
  - gnt=0001 one edge later.
  - Two captures, q=A5 with q_valid pulses.
  - Release on the first edge with req0=0, ptr=1.
- Hold limit: only req2 held continuously, d2 changes 10,11,12,13,14 each cycle.
  - Exactly 4 captures, q ends at 13.
  - gnt drops, 1 IDLE cycle, then gnt=0100 again.
- Round-robin fairness: req=4'b1111 held -> grant order 0,1,2,3,0, each with 4 captures, owner following that order.
- Handoff race: owner 1 drops req1 on the same edge req3 rises (req0=0).
  - Release with no capture on that edge.
  - Next edge gnt=1000, owner=3.
  - req3 held for 2 cycles, d3=8'hF0 -> q=F0 with two q_valid pulses.
- MAX_HOLD=1 build: req=4'b0011 held -> alternating single-capture grants 0,1,0,1. Each grant is followed by one IDLE cycle.
